bus_dma: RTL and testbench
==========================

// Module: bus_dma
// PURPOSE
//  Bus-master block-copy/fill engine: the initiator counterpart to the address decoder's responder role.
//  CPU programs it through a register window in IO bank 7 at FE00-FEFF; only addr_i[2:0] is decoded.
//  On start it requests the system bus, halts the CPU via the arbiter, and performs RAM-to-RAM copy or fill.
//  Releases the bus when done and optionally raises an interrupt.
// PARAMETERS
//  RD_LATENCY  1  cycles from m_addr_o valid to m_data_i valid; legal values 1..3.
// PORTS
//  clk_i      in   1   system clock
//  rst_n_i    in   1   asynchronous, active-low reset
//  cs_i       in   1   register window select from the address decoder
//  R_W_n      in   1   CPU direction: 1 = read, 0 = write
//  addr_i     in   3   register index
//  data_i     in   8   CPU write data
//  data_o     out  8   register read data; combinational, 0 when cs_i=0
//  bus_req_o  out  1   request bus ownership (arbiter halts CPU)
//  bus_gnt_i  in   1   bus granted
//  m_addr_o   out  16  master address
//  m_we_o     out  1   master write strobe, one cycle per byte
//  m_data_o   out  8   master write data
//  m_data_i   in   8   master read data
//  irq_o      out  1   done & irq_en, level
// BEHAVIOUR
//  Registers, written on clk_i when cs_i & ~R_W_n:
//   0/1 src lo/hi | 2/3 dst lo/hi | 4/5 len lo/hi | 7 fill byte, all R/W.
//   6 ctrl: W bit0 start, bit1 fill mode, bit2 irq_en. R: bit7 busy, bit6 done, bit2 irq_en, bit1 fill mode.
//  Writes to regs 0-5, 7, and ctrl bits1/2 are ignored while busy. A ctrl write while busy is ignored entirely.
//  Any ctrl write while idle clears done.
//  Reset: all registers 0, FSM IDLE; bus_req_o, m_we_o, irq_o, m_addr_o, m_data_o all 0.
//  Reset mid-transfer aborts immediately with no further bus cycles.
//  FSM states: IDLE, REQ, RD, WAIT, CAP, WR, DONE.
//   IDLE: start=1 with len!=0 -> REQ. start=1 with len==0 -> DONE, with no bus activity.
//   REQ: bus_req_o=1. On bus_gnt_i -> WR if fill mode, else RD.
//   RD: m_addr_o=src, m_we_o=0. Goes to WAIT for RD_LATENCY-1 cycles, then to CAP.
//   CAP: latch m_data_i into byte buffer -> WR.
//   WR: m_addr_o=dst, m_data_o=buffer (fill byte in fill mode), m_we_o=1 for exactly this cycle.
//       After WR: src+1 (copy only), dst+1, len-1, all mod 2^16 (FFFF wraps to 0000).
//       Then len==0 -> DONE, else RD (copy) or WR (fill).
//   bus_gnt_i sampled in RD and WR. If low, no strobe is issued and FSM -> REQ.
//       The byte is retried after regrant; counters do not advance.
//   DONE: bus_req_o=0, done=1 -> IDLE the next cycle.
//  bus_req_o stays high from REQ through the final WR; it is never dropped between bytes.
//  Throughput with RD_LATENCY=1: copy is 3 clk/byte; fill is 1 clk/byte.
//  busy=1 in every state except IDLE. src/dst/len read back live progress.
//  m_addr_o and m_data_o hold their last values when not driving; m_we_o=0 outside WR.
// TESTING
//  Copy: src=1000, dst=2000, len=4, RAM 11 22 33 44, start -> 2000..2003 = 11 22 33 44.
//    Expect 4 m_we_o pulses; done=1; len=0; src=1004.
//  Fill: dst=3000, len=3, fill=A5, ctrl=03 -> three consecutive single-cycle WR to 3000..3002 = A5.
//  len=0, start -> done=1 two cycles later; bus_req_o never asserted; irq_o=1 if irq_en.
//  Wrap: dst=FFFE, len=3, fill mode -> writes FFFE, FFFF, 0000; final dst=0001.
//  bus_gnt_i low for 5 cycles mid-copy -> no m_we_o while low; all bytes correct; no byte skipped or duplicated.
//  Robustness: start and reg writes while busy are ignored. rst_n_i low mid-copy -> bus_req_o=0 at once, regs=0.

Source files
------------

// File: rtl/bus_dma_if.sv
// System-bus master port of the DMA engine: ownership handshake plus a
// simple byte-wide address/data/strobe channel.
interface bus_dma_if;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic [15:0] m_addr_o;
    logic        m_we_o;
    logic [7:0]  m_data_o;
    logic [7:0]  m_data_i;

    // DMA engine side
    modport master (
        output bus_req_o,
        output m_addr_o,
        output m_we_o,
        output m_data_o,
        input  bus_gnt_i,
        input  m_data_i
    );

    // Arbiter / memory side
    modport slave (
        input  bus_req_o,
        input  m_addr_o,
        input  m_we_o,
        input  m_data_o,
        output bus_gnt_i,
        output m_data_i
    );
endinterface

// File: rtl/bus_dma.sv
// Bus-master block copy / fill engine. The CPU programs source, destination,
// length and fill byte through an 8-entry register window, then writes ctrl
// with the start bit. The engine requests the bus, moves bytes one at a time,
// drops the request when finished and flags done (optionally as an interrupt).
module bus_dma #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cs_i,
    input  logic        R_W_n,
    input  logic [2:0]  addr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        irq_o,
    bus_dma_if.master   m_bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    // Extra WAIT cycles beyond the single RD cycle, counted down to zero.
    localparam int         WAIT_CYC  = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [1:0] WAIT_INIT = WAIT_CYC[1:0];

    logic [2:0]  state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  fill_byte_q, fill_byte_d;
    logic        fill_mode_q, fill_mode_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic [7:0]  buf_q, buf_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic [15:0] addr_hold_q, addr_hold_d;
    logic [7:0]  wdata_hold_q, wdata_hold_d;

    logic        busy;
    logic        reg_wr;
    logic        gnt;
    logic [7:0]  wr_data;

    assign busy    = (state_q != S_IDLE);
    assign reg_wr  = cs_i & ~R_W_n;
    assign gnt     = m_bus.bus_gnt_i;
    assign wr_data = fill_mode_q ? fill_byte_q : buf_q;

    // Next-state logic: register writes while idle, transfer sequencing while busy.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        fill_byte_d  = fill_byte_q;
        fill_mode_d  = fill_mode_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        buf_d        = buf_q;
        wcnt_d       = wcnt_q;
        addr_hold_d  = addr_hold_q;
        wdata_hold_d = wdata_hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (reg_wr) begin
                    unique case (addr_i)
                        3'd0: src_d[7:0]  = data_i;
                        3'd1: src_d[15:8] = data_i;
                        3'd2: dst_d[7:0]  = data_i;
                        3'd3: dst_d[15:8] = data_i;
                        3'd4: len_d[7:0]  = data_i;
                        3'd5: len_d[15:8] = data_i;
                        3'd6: begin
                            fill_mode_d = data_i[1];
                            irq_en_d    = data_i[2];
                            done_d      = 1'b0;
                            // A zero-length request completes without touching the bus.
                            if (data_i[0]) begin
                                state_d = (len_q == 16'd0) ? S_DONE : S_REQ;
                            end
                        end
                        3'd7: fill_byte_d = data_i;
                        default: ;
                    endcase
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_d = fill_mode_q ? S_WR : S_RD;
                end
            end
            S_RD: begin
                addr_hold_d = src_q;
                if (!gnt) begin
                    state_d = S_REQ;
                end else if (RD_LATENCY > 1) begin
                    wcnt_d  = WAIT_INIT;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAP;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 2'd0) begin
                    state_d = S_CAP;
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            S_CAP: begin
                buf_d   = m_bus.m_data_i;
                state_d = S_WR;
            end
            S_WR: begin
                addr_hold_d  = dst_q;
                wdata_hold_d = wr_data;
                // Lost grant: no strobe, counters stay put, byte is retried after regrant.
                if (!gnt) begin
                    state_d = S_REQ;
                end else begin
                    dst_d = dst_q + 16'd1;
                    len_d = len_q - 16'd1;
                    if (!fill_mode_q) begin
                        src_d = src_q + 16'd1;
                    end
                    if (len_q == 16'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = fill_mode_q ? S_WR : S_RD;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and register update; reset aborts any transfer immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            src_q        <= 16'h0000;
            dst_q        <= 16'h0000;
            len_q        <= 16'h0000;
            fill_byte_q  <= 8'h00;
            fill_mode_q  <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            buf_q        <= 8'h00;
            wcnt_q       <= 2'd0;
            addr_hold_q  <= 16'h0000;
            wdata_hold_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            fill_byte_q  <= fill_byte_d;
            fill_mode_q  <= fill_mode_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            buf_q        <= buf_d;
            wcnt_q       <= wcnt_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    // Bus outputs: driven from live counters in RD/WR, otherwise hold the last value.
    always_comb begin
        m_bus.m_addr_o  = addr_hold_q;
        m_bus.m_data_o  = wdata_hold_q;
        m_bus.m_we_o    = 1'b0;
        m_bus.bus_req_o = (state_q == S_REQ) || (state_q == S_RD) || (state_q == S_WAIT) ||
                          (state_q == S_CAP) || (state_q == S_WR);
        if (state_q == S_RD) begin
            m_bus.m_addr_o = src_q;
        end else if (state_q == S_WR) begin
            m_bus.m_addr_o = dst_q;
            m_bus.m_data_o = wr_data;
            m_bus.m_we_o   = gnt;
        end
    end

    // Register read mux; src/dst/len expose live transfer progress.
    always_comb begin
        data_o = 8'h00;
        if (cs_i) begin
            unique case (addr_i)
                3'd0: data_o = src_q[7:0];
                3'd1: data_o = src_q[15:8];
                3'd2: data_o = dst_q[7:0];
                3'd3: data_o = dst_q[15:8];
                3'd4: data_o = len_q[7:0];
                3'd5: data_o = len_q[15:8];
                3'd6: data_o = {busy, done_q, 3'b000, irq_en_q, fill_mode_q, 1'b0};
                3'd7: data_o = fill_byte_q;
                default: data_o = 8'h00;
            endcase
        end
    end

    assign irq_o = done_q & irq_en_q;

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: expected bus writes are queued by the stimulus
// and popped by an independent write monitor; register state is checked
// through the CPU window.
module tb_bus_dma;
    localparam int RD_LATENCY = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       R_W_n = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] data_w = 8'h00;
    logic [7:0] data_r;
    logic       irq;

    bus_dma_if bus ();

    bus_dma #(.RD_LATENCY(RD_LATENCY)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cs_i    (cs),
        .R_W_n   (R_W_n),
        .addr_i  (addr),
        .data_i  (data_w),
        .data_o  (data_r),
        .irq_o   (irq),
        .m_bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int we_count = 0;
    int we_cyc [0:15];
    bit req_seen = 1'b0;
    bit we_blocked = 1'b0;
    logic gnt_block = 1'b0;
    logic [23:0] sb_q [$];

    // Hand-loaded source bytes
    logic [7:0] copy_src [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] gnt_src  [0:7] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] rob_src  [0:5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    logic [7:0] rst_src  [0:3] = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        if (a[15:2] == 14'h0400) return copy_src[a[1:0]];           // 1000..1003
        if (a[15:3] == 13'h0220) return gnt_src[a[2:0]];            // 1100..1107
        if (a >= 16'h1200 && a <= 16'h1205) return rob_src[a - 16'h1200];
        if (a[15:2] == 14'h04C0) return rst_src[a[1:0]];            // 1300..1303
        return 8'h00;
    endfunction

    // Memory model: written bytes override the preload table; read data lags the address by one clock.
    logic [7:0] mem [0:65535];
    bit         wvalid [0:65535];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) begin
        if (bus.m_we_o) begin
            mem[bus.m_addr_o]    <= bus.m_data_o;
            wvalid[bus.m_addr_o] <= 1'b1;
        end
        rd_q <= wvalid[bus.m_addr_o] ? mem[bus.m_addr_o] : init_byte(bus.m_addr_o);
        cyc  <= cyc + 1;
    end

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return wvalid[a] ? mem[a] : init_byte(a);
    endfunction

    assign bus.bus_gnt_i = bus.bus_req_o & ~gnt_block;
    assign bus.m_data_i  = rd_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (bus.bus_req_o) req_seen = 1'b1;
            if (bus.m_we_o) begin
                if (gnt_block) we_blocked = 1'b1;
                if (we_count < 16) we_cyc[we_count] = cyc;
                we_count++;
                n_total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_write: got addr %0h data %0h, want no write",
                             bus.m_addr_o, bus.m_data_o);
                end else begin
                    n_pass++;
                    e = sb_q.pop_front();
                    check("wr_addr", bus.m_addr_o, e[23:8]);
                    check("wr_data", bus.m_data_o, e[7:0]);
                end
            end
        end
    end

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; R_W_n = 1'b0; addr = a; data_w = d;
        @(posedge clk); #1;
        cs = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; R_W_n = 1'b1; addr = a;
        #2;
        d = data_r;
        cs = 1'b0;
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        cpu_wr(3'd0, s[7:0]); cpu_wr(3'd1, s[15:8]);
        cpu_wr(3'd2, d[7:0]); cpu_wr(3'd3, d[15:8]);
        cpu_wr(3'd4, n[7:0]); cpu_wr(3'd5, n[15:8]);
    endtask

    task automatic wait_idle(input int maxc);
        logic [7:0] v;
        bit fin = 1'b0;
        for (int i = 0; i < maxc && !fin; i++) begin
            @(posedge clk); #1;
            cpu_rd(3'd6, v);
            if (!v[7]) fin = 1'b1;
        end
        check("xfer_finished", fin, 1'b1);
    endtask

    task automatic wait_we(input int n, input int maxc);
        bit hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(posedge clk); #1;
            if (we_count >= n) hit = 1'b1;
        end
        check("we_reached", hit, 1'b1);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        cpu_rd(a, v);
        check(name, v, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int snap;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_req", bus.bus_req_o, 1'b0);
        check("rst_m_we",    bus.m_we_o,    1'b0);
        check("rst_m_addr",  bus.m_addr_o,  16'h0000);
        check("rst_m_data",  bus.m_data_o,  8'h00);
        check("rst_irq",     irq,           1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_reg%0d", i), 3'(i), 8'h00);

        // Copy 1000 -> 2000, 4 bytes
        prog(16'h1000, 16'h2000, 16'd4);
        for (int i = 0; i < 4; i++) sb_q.push_back({16'h2000 + 16'(i), copy_src[i]});
        we_count = 0;
        cpu_wr(3'd6, 8'h01);
        wait_idle(200);
        check("copy_we_count", we_count, 4);
        check("copy_byte_period", we_cyc[1] - we_cyc[0], 3);
        rd_chk("copy_ctrl",  3'd6, 8'h40);
        rd_chk("copy_len_lo", 3'd4, 8'h00);
        rd_chk("copy_len_hi", 3'd5, 8'h00);
        rd_chk("copy_src_lo", 3'd0, 8'h04);
        rd_chk("copy_src_hi", 3'd1, 8'h10);
        rd_chk("copy_dst_lo", 3'd2, 8'h04);
        for (int i = 0; i < 4; i++) check("copy_mem", mem_byte(16'h2000 + 16'(i)), copy_src[i]);
        check("copy_sb_empty", sb_q.size(), 0);

        // Fill 3000..3002 with A5
        cpu_wr(3'd2, 8'h00); cpu_wr(3'd3, 8'h30);
        cpu_wr(3'd4, 8'h03); cpu_wr(3'd5, 8'h00);
        cpu_wr(3'd7, 8'hA5);
        for (int i = 0; i < 3; i++) sb_q.push_back({16'h3000 + 16'(i), 8'hA5});
        we_count = 0;
        cpu_wr(3'd6, 8'h03);
        wait_idle(100);
        check("fill_we_count", we_count, 3);
        check("fill_gap01", we_cyc[1] - we_cyc[0], 1);
        check("fill_gap12", we_cyc[2] - we_cyc[1], 1);
        rd_chk("fill_ctrl",   3'd6, 8'h42);
        rd_chk("fill_dst_lo", 3'd2, 8'h03);

        // Zero length with irq enabled: done without any bus request
        req_seen = 1'b0;
        we_count = 0;
        cpu_wr(3'd6, 8'h05);
        rd_chk("len0_ctrl_busy", 3'd6, 8'h84);
        @(posedge clk); #1;
        rd_chk("len0_ctrl_done", 3'd6, 8'h44);
        check("len0_irq", irq, 1'b1);
        check("len0_no_req", req_seen, 1'b0);
        check("len0_no_we", we_count, 0);
        cpu_wr(3'd6, 8'h00);
        check("len0_irq_clr", irq, 1'b0);
        rd_chk("len0_ctrl_clr", 3'd6, 8'h00);

        // Fill across the top of the address space
        cpu_wr(3'd2, 8'hFE); cpu_wr(3'd3, 8'hFF);
        cpu_wr(3'd4, 8'h03); cpu_wr(3'd5, 8'h00);
        cpu_wr(3'd7, 8'h5A);
        sb_q.push_back({16'hFFFE, 8'h5A});
        sb_q.push_back({16'hFFFF, 8'h5A});
        sb_q.push_back({16'h0000, 8'h5A});
        we_count = 0;
        cpu_wr(3'd6, 8'h03);
        wait_idle(100);
        check("wrap_we_count", we_count, 3);
        rd_chk("wrap_dst_lo", 3'd2, 8'h01);
        rd_chk("wrap_dst_hi", 3'd3, 8'h00);

        // Grant withdrawn for 5 cycles mid-copy
        prog(16'h1100, 16'h2100, 16'd8);
        for (int i = 0; i < 8; i++) sb_q.push_back({16'h2100 + 16'(i), gnt_src[i]});
        we_count = 0;
        we_blocked = 1'b0;
        cpu_wr(3'd6, 8'h01);
        wait_we(3, 200);
        snap = we_count;
        gnt_block = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("gnt_req_held", bus.bus_req_o, 1'b1);
        check("gnt_no_progress", we_count, snap);
        gnt_block = 1'b0;
        wait_idle(300);
        check("gnt_we_count", we_count, 8);
        check("gnt_no_we_blocked", we_blocked, 1'b0);
        for (int i = 0; i < 8; i++) check("gnt_mem", mem_byte(16'h2100 + 16'(i)), gnt_src[i]);
        check("gnt_sb_empty", sb_q.size(), 0);

        // Register and ctrl writes while busy are ignored
        prog(16'h1200, 16'h2200, 16'd6);
        for (int i = 0; i < 6; i++) sb_q.push_back({16'h2200 + 16'(i), rob_src[i]});
        we_count = 0;
        cpu_wr(3'd6, 8'h01);
        cpu_wr(3'd0, 8'h55);
        cpu_wr(3'd6, 8'h07);
        cpu_wr(3'd7, 8'hFF);
        wait_idle(300);
        check("rob_we_count", we_count, 6);
        rd_chk("rob_ctrl",   3'd6, 8'h40);
        rd_chk("rob_src_lo", 3'd0, 8'h06);
        rd_chk("rob_src_hi", 3'd1, 8'h12);
        rd_chk("rob_fill",   3'd7, 8'h5A);
        check("rob_irq", irq, 1'b0);

        // Reset in the middle of a copy
        prog(16'h1300, 16'h2300, 16'd4);
        for (int i = 0; i < 4; i++) sb_q.push_back({16'h2300 + 16'(i), rst_src[i]});
        we_count = 0;
        cpu_wr(3'd6, 8'h01);
        wait_we(2, 200);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus_req", bus.bus_req_o, 1'b0);
        check("mid_rst_m_we",    bus.m_we_o,    1'b0);
        check("mid_rst_m_addr",  bus.m_addr_o,  16'h0000);
        sb_q.delete();
        snap = we_count;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("mid_rst_no_more_we", we_count, snap);
        rd_chk("mid_rst_src_lo", 3'd0, 8'h00);
        rd_chk("mid_rst_dst_hi", 3'd3, 8'h00);
        rd_chk("mid_rst_len_lo", 3'd4, 8'h00);
        rd_chk("mid_rst_ctrl",   3'd6, 8'h00);
        rd_chk("mid_rst_fill",   3'd7, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
